// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared defaults, constants and width helpers for the tube scanner
package tube_pkg;

  localparam int NDIG_DEF = 8;
  localparam int DIV_DEF  = 50000;
  localparam int DEAD_DEF = 16;

  // Wide enough for the largest supported digit count; callers slice to NDIG.
  localparam logic [7:0] AN_OFF = 8'hFF;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tube_lzb.sv
// rtl/tube_lzb.sv - leading-zero blank mask for the displayed hex value
module tube_lzb
  import tube_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic [4*NDIG-1:0] value,
  input  logic              lzb,
  output logic [NDIG-1:0]   blank
);

  always_comb begin
    logic [NDIG:0] zero_above;
    // zero_above[i] is set when digits NDIG-1 down to i are all zero
    zero_above       = '0;
    zero_above[NDIG] = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (value[4*i +: 4] == 4'h0);
    end
    blank = '0;
    for (int i = 1; i < NDIG; i++) begin
      blank[i] = lzb && zero_above[i];
    end
  end

endmodule

// File: rtl/tube_scan.sv
// rtl/tube_scan.sv - time-multiplexed seven-segment scan controller with frame-aligned commit
module tube_scan
  import tube_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int DIV  = DIV_DEF,
  parameter int DEAD = DEAD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic [NDIG-1:0]   en_mask,
  input  logic              lzb,
  output logic [3:0]        num,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame,
  output logic              busy
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam int IW = idx_w(NDIG);
  localparam int AW = 6 * NDIG;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_ALL   = AN_OFF[NDIG-1:0];

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            frame_q, frame_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   sh_q, sh_d;
  logic [AW-1:0]   act_q, act_d;
  logic [3:0]      num_q, num_d;
  logic            dp_q, dp_d;
  logic [NDIG-1:0] an_q, an_d;

  logic [AW-1:0]     wr_word;
  logic [4*NDIG-1:0] act_data;
  logic [NDIG-1:0]   act_dp, act_en, blank;
  logic              slot_end, wrap, dark;

  assign wr_word                    = {data, dp_mask, en_mask};
  assign {act_data, act_dp, act_en} = act_q;

  tube_lzb #(.NDIG(NDIG)) u_lzb (
    .value (act_data),
    .lzb   (lzb),
    .blank (blank)
  );

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_d = wrap;

    // A write landing on the wrap cycle goes straight to the active copy.
    sh_d   = wr ? wr_word : sh_q;
    pend_d = pend_q | wr;
    act_d  = act_q;
    if (wrap) begin
      pend_d = 1'b0;
      if (wr) begin
        act_d = wr_word;
      end else if (pend_q) begin
        act_d = sh_q;
      end
    end

    dark  = (cnt_q < DEAD_C) || !act_en[idx_q] || blank[idx_q];
    num_d = act_data[{idx_q, 2'b00} +: 4];
    an_d  = dark ? AN_ALL : ~(NDIG'(1) << idx_q);
    dp_d  = !dark && act_dp[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
      pend_q  <= 1'b0;
      sh_q    <= '0;
      act_q   <= '0;
      num_q   <= 4'h0;
      dp_q    <= 1'b0;
      an_q    <= AN_ALL;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      sh_q    <= sh_d;
      act_q   <= act_d;
      num_q   <= num_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign num   = num_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;
  assign busy  = pend_q;

endmodule

// File: tb/tb_tube_scan.sv
// tb/tb_tube_scan.sv - scoreboard bench for tube_scan with NDIG=4, DIV=8, DEAD=2
module tb_tube_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  en_mask = 4'h0;
  logic        lzb = 1'b0;
  logic [3:0]  num;
  logic        dp;
  logic [3:0]  an;
  logic        frame;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic       in_run = 1'b0;
  logic [3:0] cur_an = 4'hF;
  int         run_len = 0;

  tube_scan #(.NDIG(4), .DIV(8), .DEAD(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .data    (data),
    .dp_mask (dp_mask),
    .en_mask (en_mask),
    .lzb     (lzb),
    .num     (num),
    .dp      (dp),
    .an      (an),
    .frame   (frame),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] n, input logic d);
    exp_q.push_back({a, n, d});
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_wr(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] enm);
    data    = d;
    dp_mask = dpm;
    en_mask = enm;
    wr      = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  // Monitor: one scoreboard entry per lit digit slot, plus frame and dark-dp checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_run  <= 1'b0;
      run_len <= 0;
    end else begin
      if (frame || (cyc % 32 == 0 && cyc != 0))
        chk("frame", {31'b0, frame}, {31'b0, (cyc % 32 == 0 && cyc != 0)});
      if (an != 4'hF) begin
        if (!in_run || an != cur_an) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_digit at cyc %0d: got an=%b num=%h dp=%b, want all dark",
                     cyc, an, num, dp);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("digit{an,num,dp}", {23'b0, an, num, dp}, {23'b0, e});
          end
          in_run  <= 1'b1;
          cur_an  <= an;
          run_len <= 1;
        end else begin
          run_len <= run_len + 1;
        end
      end else begin
        chk("dp_dark", {31'b0, dp}, 32'd0);
        if (in_run) chk("lit_len", run_len, 32'd6);
        in_run <= 1'b0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_num", {28'b0, num}, 32'h0);
    chk("rst_dp", {31'b0, dp}, 32'h0);
    chk("rst_frame", {31'b0, frame}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nothing written yet: active en_mask is 0, so frames 0 and 1 stay dark.
    wait_cyc(20);
    chk("idle_num", {28'b0, num}, 32'h0);
    chk("idle_an", {28'b0, an}, 32'hF);

    wait_cyc(40);
    do_wr(16'h1234, 4'b0100, 4'hF);
    chk("busy_after_wr", {31'b0, busy}, 32'd1);
    push(4'b1110, 4'h4, 1'b0);
    push(4'b1101, 4'h3, 1'b0);
    push(4'b1011, 4'h2, 1'b1);
    push(4'b0111, 4'h1, 1'b0);
    wait_cyc(63);
    chk("busy_before_wrap", {31'b0, busy}, 32'd1);
    wait_cyc(64);
    chk("busy_after_wrap", {31'b0, busy}, 32'd0);

    wait_cyc(70);
    lzb = 1'b1;
    do_wr(16'h0050, 4'b0000, 4'hF);
    push(4'b1110, 4'h0, 1'b0);
    push(4'b1101, 4'h5, 1'b0);

    wait_cyc(100);
    do_wr(16'h0000, 4'hF, 4'hF);
    push(4'b1110, 4'h0, 1'b1);

    wait_cyc(135);
    do_wr(16'hAAAA, 4'h0, 4'hF);
    wait_cyc(140);
    do_wr(16'hBBBB, 4'b0001, 4'b1011);
    chk("busy_two_writes", {31'b0, busy}, 32'd1);
    push(4'b1110, 4'hB, 1'b1);
    push(4'b1101, 4'hB, 1'b0);
    push(4'b0111, 4'hB, 1'b0);
    wait_cyc(159);
    chk("busy_pre_wrap2", {31'b0, busy}, 32'd1);
    wait_cyc(160);
    chk("busy_post_wrap2", {31'b0, busy}, 32'd0);
    wait_cyc(161);
    lzb = 1'b0;

    // Write on the exact wrap cycle (captured at posedge 192).
    wait_cyc(191);
    chk("busy_pre_bypass", {31'b0, busy}, 32'd0);
    do_wr(16'hCCCC, 4'h0, 4'hF);
    chk("busy_bypass", {31'b0, busy}, 32'd0);
    push(4'b1110, 4'hC, 1'b0);
    push(4'b1101, 4'hC, 1'b0);
    push(4'b1011, 4'hC, 1'b0);

    wait_cyc(200);
    do_wr(16'hDDDD, 4'hF, 4'hF);
    chk("busy_pending", {31'b0, busy}, 32'd1);
    wait_cyc(213);
    rst_n = 1'b0;
    #1;
    chk("async_an", {28'b0, an}, 32'hF);
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_num", {28'b0, num}, 32'h0);
    chk("async_dp", {31'b0, dp}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(40);
    chk("busy_lost", {31'b0, busy}, 32'd0);
    chk("num_after_rst", {28'b0, num}, 32'h0);
    wait_cyc(70);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
